// File: rtl/i2c_target.sv
`default_nettype none
// ==========================================================================
// i2c_target : single-address I2C target (no clock stretching)  | rev 1.0
// ==========================================================================
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       addr_hit
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic       scl_hist_q, scl_hist_d;
  logic       sda_hist_q, sda_hist_d;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       load_q, load_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addr_hit_q, addr_hit_d;
  logic       busy_q, busy_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  assign start_det =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_sclk};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sdat};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Bus-side flops reset to 1 so leaving reset on an idle bus makes no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
    end
  end

  // In the ACK states sda_oe_q doubles as the phase: low = waiting to drive.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q == 3'd7)
            state_d = (shift_q == ADDR) ? S_ADDR_ACK : S_IGNORE;
        end
        S_ADDR_ACK: begin
          if (scl_fall && sda_oe_q)
            state_d = rw_q ? S_RD_BYTE : S_WR_BYTE;
        end
        S_WR_BYTE: begin
          if (scl_rise && bit_cnt_q == 3'd7)
            state_d = S_WR_ACK;
        end
        S_WR_ACK: begin
          if (scl_fall && sda_oe_q)
            state_d = S_WR_BYTE;
        end
        S_RD_BYTE: begin
          if (scl_fall && !load_q && bit_cnt_q == 3'd7)
            state_d = S_RD_ACK;
        end
        S_RD_ACK: begin
          if (scl_rise)
            state_d = sda_s ? S_IGNORE : S_RD_BYTE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    load_d     = load_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    addr_hit_d = 1'b0;
    busy_d     = busy_q;
    if (start_det) begin
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      load_d    = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      sda_oe_d  = 1'b0;
      load_d    = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_ADDR) begin
                rw_d       = sda_s;
                addr_hit_d = (shift_q == ADDR);
              end else begin
                rx_data_d  = {shift_q, sda_s};
                rx_valid_d = 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (state_q == S_ADDR_ACK && rw_q && scl_rise)
            tx_req_d = 1'b1;
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == S_ADDR_ACK && rw_q) begin
              // ACK release and first read bit share this falling edge.
              shift_d   = tx_data[6:0];
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd0;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (load_q) begin
              shift_d   = tx_data[6:0];
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd0;
              load_d    = 1'b0;
            end else if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
            end else begin
              shift_d   = {shift_q[5:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && !sda_s) begin
            tx_req_d = 1'b1;
            load_d   = 1'b1;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign addr_hit = addr_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ==========================================================================
// tb_i2c_target : bus-level master model with scoreboard      | rev 1.0
// ==========================================================================
module tb_i2c_target;

  localparam logic [6:0] ADDR = 7'h50;
  localparam int Q = 6;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, addr_hit;

  int checks = 0;
  int errors = 0;
  int n_hit = 0, n_rxv = 0, n_txreq = 0, n_unexp = 0;
  logic [7:0] exp_rx_q[$];

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_sclk (scl),
    .i2c_sdat (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .addr_hit (addr_hit)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (addr_hit) n_hit++;
      if (tx_req) n_txreq++;
      if (rx_valid) begin
        n_rxv++;
        if (exp_rx_q.size() == 0) n_unexp++;
        else check_eq("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_q.pop_front()});
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    m_sda_low = 1'b0; wclk(Q);
    scl = 1'b1;       wclk(Q);
    m_sda_low = 1'b1; wclk(Q);
    scl = 1'b0;       wclk(Q);
  endtask

  task automatic m_stop;
    m_sda_low = 1'b1; wclk(Q);
    scl = 1'b1;       wclk(Q);
    m_sda_low = 1'b0; wclk(2*Q);
  endtask

  task automatic m_bit(input logic b, output logic sampled);
    m_sda_low = ~b; wclk(Q);
    scl = 1'b1;     wclk(H/2);
    sampled = sda_bus;
    wclk(H/2);
    scl = 1'b0;     wclk(Q);
  endtask

  // Returns the bus level in the 9th bit: 0 means the target acknowledged.
  task automatic m_wr_byte(input logic [7:0] d, output logic ack_lvl);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack_lvl);
  endtask

  task automatic m_rd_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    tx_data = next_tx;
    m_bit(~m_ack, s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         h0, r0, t0;

    wclk(5);
    check_eq("rst_busy", {31'h0, busy}, 0);
    check_eq("rst_rx_data", {24'h0, rx_data}, 0);
    check_eq("rst_strobes", {29'h0, rx_valid, tx_req, addr_hit}, 0);
    check_eq("rst_sda", {31'h0, sda_bus}, 1);
    rst = 1'b0;
    wclk(20);
    check_eq("post_rst_busy", {31'h0, busy}, 0);
    check_eq("post_rst_strobes", n_hit + n_rxv + n_txreq, 0);

    // basic write
    h0 = n_hit; r0 = n_rxv;
    m_start;
    m_wr_byte(8'hA0, ack);
    check_eq("wr_addr_ack", {31'h0, ack}, 0);
    check_eq("wr_busy", {31'h0, busy}, 1);
    exp_rx_q.push_back(8'h3C);
    m_wr_byte(8'h3C, ack);
    check_eq("wr_data_ack", {31'h0, ack}, 0);
    m_stop;
    check_eq("wr_rx_data", {24'h0, rx_data}, 32'h3C);
    check_eq("wr_hits", n_hit - h0, 1);
    check_eq("wr_rxv", n_rxv - r0, 1);
    check_eq("wr_busy_stop", {31'h0, busy}, 0);

    // foreign address
    h0 = n_hit; r0 = n_rxv;
    m_start;
    m_wr_byte(8'hA2, ack);
    check_eq("miss_addr_nack", {31'h0, ack}, 1);
    m_wr_byte(8'h55, ack);
    check_eq("miss_data_nack", {31'h0, ack}, 1);
    m_stop;
    check_eq("miss_hits", n_hit - h0, 0);
    check_eq("miss_rxv", n_rxv - r0, 0);

    // read two bytes, ACK then NACK
    h0 = n_hit; t0 = n_txreq;
    m_start;
    tx_data = 8'h96;
    m_wr_byte(8'hA1, ack);
    check_eq("rd_addr_ack", {31'h0, ack}, 0);
    m_rd_byte(1'b1, 8'h5A, d);
    check_eq("rd_byte0", {24'h0, d}, 32'h96);
    m_rd_byte(1'b0, 8'h00, d);
    check_eq("rd_byte1", {24'h0, d}, 32'h5A);
    wclk(4);
    check_eq("rd_released", {31'h0, sda_bus}, 1);
    check_eq("rd_txreq", n_txreq - t0, 2);
    m_stop;
    check_eq("rd_hits", n_hit - h0, 1);

    // partial write byte then repeated START into a read
    h0 = n_hit; r0 = n_rxv; t0 = n_txreq;
    m_start;
    m_wr_byte(8'hA0, ack);
    check_eq("rs_addr_ack", {31'h0, ack}, 0);
    for (int i = 0; i < 4; i++) m_bit(i[0], ack);
    m_start;
    tx_data = 8'hC3;
    m_wr_byte(8'hA1, ack);
    check_eq("rs_rd_ack", {31'h0, ack}, 0);
    m_rd_byte(1'b0, 8'h00, d);
    check_eq("rs_rd_byte", {24'h0, d}, 32'hC3);
    m_stop;
    check_eq("rs_rxv", n_rxv - r0, 0);
    check_eq("rs_hits", n_hit - h0, 2);
    check_eq("rs_txreq", n_txreq - t0, 1);

    // reset while the target holds the ACK low
    m_start;
    for (int i = 7; i >= 0; i--) m_bit(i == 7 || i == 5, ack);
    m_sda_low = 1'b0;
    wclk(1);
    check_eq("ack_driven", {31'h0, sda_bus}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_release_sda", {31'h0, sda_bus}, 1);
    wclk(2);
    rst = 1'b0;
    wclk(4);
    check_eq("rst_mid_busy", {31'h0, busy}, 0);
    r0 = n_rxv;
    m_start;
    m_wr_byte(8'hA0, ack);
    check_eq("after_rst_ack", {31'h0, ack}, 0);
    exp_rx_q.push_back(8'hE7);
    m_wr_byte(8'hE7, ack);
    check_eq("after_rst_data_ack", {31'h0, ack}, 0);
    m_stop;
    check_eq("after_rst_rxv", n_rxv - r0, 1);

    // randomized transactions against the protocol model
    for (int t = 0; t < 16; t++) begin
      logic [6:0] a;
      logic       rw, match;
      int         nb;
      logic [7:0] txb[4];
      a = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      match = (a == ADDR);
      for (int i = 0; i < 4; i++) txb[i] = 8'($urandom);
      h0 = n_hit; r0 = n_rxv; t0 = n_txreq;
      m_start;
      tx_data = txb[0];
      m_wr_byte({a, rw}, ack);
      check_eq("rnd_addr_ack", {31'h0, ack}, {31'h0, ~match});
      if (!rw) begin
        for (int i = 0; i < nb; i++) begin
          if (match) exp_rx_q.push_back(txb[i+1]);
          m_wr_byte(txb[i+1], ack);
          check_eq("rnd_wr_ack", {31'h0, ack}, {31'h0, ~match});
        end
      end else if (match) begin
        for (int i = 0; i < nb; i++) begin
          m_rd_byte(i != nb - 1, txb[i+1], d);
          check_eq("rnd_rd_data", {24'h0, d}, {24'h0, txb[i]});
        end
      end else begin
        m_rd_byte(1'b0, 8'h00, d);
        check_eq("rnd_rd_idle", {24'h0, d}, 32'hFF);
      end
      m_stop;
      check_eq("rnd_hits", n_hit - h0, match ? 1 : 0);
      check_eq("rnd_rxv", n_rxv - r0, (match && !rw) ? nb : 0);
      check_eq("rnd_txreq", n_txreq - t0, (match && rw) ? nb : 0);
      check_eq("rnd_busy", {31'h0, busy}, 0);
    end

    wclk(4);
    check_eq("rx_unexpected", n_unexp, 0);
    check_eq("rx_queue_left", exp_rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h50, 7-bit bus address this target answers to.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops on each bus input (legal range 2..3).
REQ-003 clk  input  1  system clock; clk frequency SHALL be >= 8x SCL frequency.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i2c_sclk  input  1  I2C clock from bus master; never driven by this block (no clock stretching).
REQ-006 i2c_sdat  inout  1  I2C data, open-drain; block drives only 1'b0 or 1'bz.
REQ-007 rx_data  output  8  last byte written by master.
REQ-008 rx_valid  output  1  one-cycle strobe, rx_data updated.
REQ-009 tx_data  input  8  byte to return on a master read.
REQ-010 tx_req  output  1  one-cycle strobe, tx_data required by next SCL falling edge.
REQ-011 busy  output  1  high from any START to the following STOP.
REQ-012 addr_hit  output  1  one-cycle strobe on address match.

Function
REQ-013 i2c_sclk and i2c_sdat SHALL pass through SYNC_STAGES flops plus one history flop; edges are detected from the synchronized value and its history; pin-to-event latency is SYNC_STAGES+1 clk.
REQ-014 START = synchronized SDA falling while synchronized SCL high; STOP = SDA rising while SCL high; both are recognized in every state, including mid-byte.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-016 START in any state -> ADDR, bit counter cleared, SDA released, busy=1 (repeated START is handled identically).
REQ-017 STOP in any state -> IDLE, SDA released, busy=0.
REQ-018 Bits are sampled on the SCL rising edge, MSB first; SDA is only changed on the SCL falling edge.
REQ-019 ADDR: after 8 bits, if byte[7:1]==ADDR -> ADDR_ACK with addr_hit pulse; else -> IGNORE, SDA never driven.
REQ-020 ADDR_ACK: drive SDA low from the next SCL falling edge to the following SCL falling edge; then go to WR_BYTE if byte[0]=0, else to RD_BYTE.
REQ-021 WR_BYTE: after the 8th rising edge, load rx_data and pulse rx_valid in the following clk cycle; -> WR_ACK.
REQ-022 WR_ACK: always ACK (SDA low for one SCL period, same timing as REQ-020); -> WR_BYTE.
REQ-023 Read ACK bit: tx_req pulses on the SCL rising edge of the ADDR_ACK bit (read address) and of each master ACK bit in RD_ACK.
REQ-024 RD_BYTE: latch tx_data on the next SCL falling edge and drive bit 7; shift one bit per falling edge; a 1 bit is released (z), never driven high.
REQ-025 After 8 bits, release SDA on the falling edge -> RD_ACK; sample SDA on the rising edge: 0 (ACK) -> RD_BYTE with tx_req; 1 (NACK) -> IGNORE.
REQ-026 IGNORE: SDA released; leave only on START or STOP.
REQ-027 If START/STOP and an SCL edge are detected in the same cycle, START/STOP SHALL take priority.
REQ-028 Bit counter is 3 bits and wraps 7->0 only at byte boundaries; the counter is cleared on START.

Reset
REQ-029 While rst=1 at a clk edge: state=IDLE, SDA released (z), rx_data=8'h00, rx_valid=0, tx_req=0, addr_hit=0, busy=0.
REQ-030 Synchronizer and history flops reset to 1 (idle bus) so that release of reset SHALL NOT produce a false START/STOP.
REQ-031 Reset asserted mid-transfer SHALL release SDA within one clk; the block then waits for a fresh START.

Verification
REQ-032 Write 0xA0 (addr 0x50, W), then 0x3C, then STOP -> ACK on both 9th bits; addr_hit pulse once; rx_valid pulse once; rx_data=8'h3C; busy low after STOP.
REQ-033 Send addr byte 0xA2 (0x51) -> no SDA drive during ACK bit (master sees NACK); no rx_valid; state IGNORE until STOP.
REQ-034 Read 0xA1 with tx_data=8'h96; master ACKs then NACKs with tx_data=8'h5A -> bus bits 10010110 then 01011010; exactly two tx_req pulses; SDA released after NACK.
REQ-035 Write 0xA0, send 4 bits, then repeated START and 0xA1 -> partial byte discarded; no rx_valid; read phase proceeds normally.
REQ-036 Assert rst while driving an ACK low -> SDA is z on the next clk; the next transaction after START completes normally.
REQ-037 Release reset with SCL=SDA=1 held -> busy stays 0; no strobe fires.
